// File: rtl/mod16_issue_ctrl.sv
// mod16_issue_ctrl
// Issue/capture sequencer in front of the registered 16-bit modulo unit.
// A request is accepted over req_valid/req_ready, its operands are latched
// and held on mod_num/mod_imp while the modulo unit computes. The remainder
// is then captured and returned over rsp_valid/rsp_ready with a
// divide-by-zero flag.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active low
//   req_valid   request present
//   req_ready   sequencer idle and able to accept
//   req_num     dividend
//   req_den     divisor
//   mod_num     dividend held on the modulo unit input
//   mod_imp     divisor held on the modulo unit input
//   mod_result  remainder from the modulo unit
//   rsp_valid   response present
//   rsp_ready   consumer accepts the response
//   rsp_result  captured remainder (0 on divide by zero)
//   rsp_dz      divisor was zero
//   busy        sequencer not idle
module mod16_issue_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_num,
    input  logic [15:0] req_den,
    output logic [15:0] mod_num,
    output logic [15:0] mod_imp,
    input  logic [15:0] mod_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_dz,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] num_q;
    logic [15:0] den_q;
    logic [15:0] res_q;
    logic        dz_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        num_q   <= req_num;
                        den_q   <= req_den;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A zero divisor resolves one edge after accept without
                    // ever sampling the modulo unit.
                    if (den_q == 16'd0) begin
                        res_q   <= '0;
                        dz_q    <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q == LAT) begin
                        res_q   <= mod_result;
                        dz_q    <= 1'b0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All handshake outputs are pure decodes of the state register.
    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign mod_num    = num_q;
    assign mod_imp    = den_q;
    assign rsp_result = res_q;
    assign rsp_dz     = dz_q;

endmodule

// File: tb/tb_mod16_issue_ctrl.sv
module tb_mod16_issue_ctrl;

    localparam int N = 3;  // instance g runs with LATENCY = g+1

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic [15:0] req_num    [N];
    logic [15:0] req_den    [N];
    logic [15:0] mod_num    [N];
    logic [15:0] mod_imp    [N];
    logic [15:0] mod_result [N];
    logic        rsp_valid  [N];
    logic        rsp_ready  [N];
    logic [15:0] rsp_result [N];
    logic        rsp_dz     [N];
    logic        busy       [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [15:0] pipe [g+1];

        mod16_issue_ctrl #(.LATENCY(g + 1)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_num    (req_num[g]),
            .req_den    (req_den[g]),
            .mod_num    (mod_num[g]),
            .mod_imp    (mod_imp[g]),
            .mod_result (mod_result[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_result (rsp_result[g]),
            .rsp_dz     (rsp_dz[g]),
            .busy       (busy[g])
        );

        // Registered modulo unit with g+1 pipeline stages.
        always @(posedge clk) begin
            pipe[0] <= (mod_imp[g] == 16'd0) ? 16'd0 : mod_num[g] % mod_imp[g];
            for (int j = 1; j <= g; j++) pipe[j] <= pipe[j-1];
        end
        assign mod_result[g] = pipe[g];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: remainder/flag and edges from accept to rsp_valid.
    function automatic logic [15:0] ref_res(input logic [15:0] n, input logic [15:0] d);
        return (d == 16'd0) ? 16'd0 : n % d;
    endfunction

    function automatic int ref_lat(input int idx, input logic [15:0] d);
        return (d == 16'd0) ? 1 : (idx + 1) + 1;
    endfunction

    // One full transaction on instance idx. hold = cycles of back-pressure
    // after rsp_valid; early = rsp_ready high already while waiting;
    // toggle = scramble request inputs during wait; nxt_* = request left
    // presented on req_* after the accept.
    task automatic do_txn(input int idx, input logic [15:0] n, input logic [15:0] d,
                          input int hold, input bit early, input bit toggle,
                          input bit nxt_v, input logic [15:0] nxt_n, input logic [15:0] nxt_d);
        int w;
        int e;
        logic [15:0] er;
        logic        edz;
        er  = ref_res(n, d);
        edz = (d == 16'd0);
        req_num[idx]   = n;
        req_den[idx]   = d;
        req_valid[idx] = 1'b1;
        rsp_ready[idx] = early;
        w = 0;
        while (req_ready[idx] !== 1'b1 && w < 60) begin
            tick();
            w++;
        end
        checks++;
        if (w >= 60) begin
            failures++;
            $display("FAIL accept_timeout idx=%0d got=no_ready exp=ready", idx);
            req_valid[idx] = 1'b0;
            return;
        end
        tick();  // accept edge
        req_valid[idx] = nxt_v;
        req_num[idx]   = nxt_n;
        req_den[idx]   = nxt_d;
        checks++;
        if (mod_num[idx] !== n || mod_imp[idx] !== d || busy[idx] !== 1'b1) begin
            failures++;
            $display("FAIL operands idx=%0d got=%h/%h busy=%b exp=%h/%h busy=1",
                     idx, mod_num[idx], mod_imp[idx], busy[idx], n, d);
        end
        e = 0;
        while (rsp_valid[idx] !== 1'b1 && e < 40) begin
            if (toggle) begin
                req_num[idx] = 16'($urandom);
                req_den[idx] = 16'($urandom);
            end
            tick();
            e++;
            checks++;
            if (mod_num[idx] !== n || mod_imp[idx] !== d) begin
                failures++;
                $display("FAIL stability idx=%0d got=%h/%h exp=%h/%h",
                         idx, mod_num[idx], mod_imp[idx], n, d);
            end
        end
        checks++;
        if (e != ref_lat(idx, d)) begin
            failures++;
            $display("FAIL latency idx=%0d got=%0d exp=%0d", idx, e, ref_lat(idx, d));
        end
        checks++;
        if (rsp_result[idx] !== er || rsp_dz[idx] !== edz) begin
            failures++;
            $display("FAIL result idx=%0d n=%h d=%h got=%h dz=%b exp=%h dz=%b",
                     idx, n, d, rsp_result[idx], rsp_dz[idx], er, edz);
        end
        if (!early) begin
            for (int k = 0; k < hold; k++) begin
                tick();
                checks++;
                if (rsp_valid[idx] !== 1'b1 || req_ready[idx] !== 1'b0 ||
                    rsp_result[idx] !== er || rsp_dz[idx] !== edz) begin
                    failures++;
                    $display("FAIL hold idx=%0d got=v%b r%b %h exp=v1 r0 %h",
                             idx, rsp_valid[idx], req_ready[idx], rsp_result[idx], er);
                end
            end
            rsp_ready[idx] = 1'b1;
        end
        tick();  // response handshake edge
        rsp_ready[idx] = 1'b0;
        checks++;
        if (rsp_valid[idx] !== 1'b0 || req_ready[idx] !== 1'b1 || busy[idx] !== 1'b0) begin
            failures++;
            $display("FAIL release idx=%0d got=v%b r%b b%b exp=v0 r1 b0",
                     idx, rsp_valid[idx], req_ready[idx], busy[idx]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (req_ready[i] !== 1'b1 || rsp_valid[i] !== 1'b0 || busy[i] !== 1'b0 ||
                mod_num[i] !== 16'd0 || mod_imp[i] !== 16'd0 ||
                rsp_result[i] !== 16'd0 || rsp_dz[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset idx=%0d got=r%b v%b b%b %h %h %h dz%b exp=r1 v0 b0 0 0 0 dz0",
                         i, req_ready[i], rsp_valid[i], busy[i], mod_num[i], mod_imp[i],
                         rsp_result[i], rsp_dz[i]);
            end
        end
        rst = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (req_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release idx=%0d got=r%b b%b exp=r1 b0", i, req_ready[i], busy[i]);
            end
        end
    endtask

    task automatic test_basic();
        do_txn(0, 16'd8, 16'd3, 0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        do_txn(0, 16'hFFFF, 16'hFFFF, 1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        do_txn(0, 16'd5, 16'd1, 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic test_div_zero();
        do_txn(0, 16'hFFFF, 16'd0, 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        do_txn(2, 16'h0000, 16'd0, 2, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic test_back_pressure();
        do_txn(0, 16'd1, 16'd2, 5, 1'b0, 1'b0, 1'b1, 16'd2, 16'd1);
        do_txn(0, 16'd2, 16'd1, 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic test_reset_mid();
        req_num[2]   = 16'h1234;
        req_den[2]   = 16'h0010;
        req_valid[2] = 1'b1;
        tick();  // accept
        req_valid[2] = 1'b0;
        tick();  // in WAIT, count advanced once
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (req_ready[2] !== 1'b1 || busy[2] !== 1'b0 || rsp_valid[2] !== 1'b0 ||
            mod_num[2] !== 16'd0 || mod_imp[2] !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid idx=2 got=r%b b%b v%b %h %h exp=r1 b0 v0 0 0",
                     req_ready[2], busy[2], rsp_valid[2], mod_num[2], mod_imp[2]);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (rsp_valid[2] !== 1'b0) begin
                failures++;
                $display("FAIL abandoned_rsp idx=2 got=%b exp=0", rsp_valid[2]);
            end
        end
        do_txn(2, 16'h0011, 16'h0010, 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic test_stability();
        do_txn(1, 16'hBEEF, 16'h0123, 0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
        do_txn(1, 16'h0007, 16'hFFFF, 1, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int          idx;
            logic [15:0] n;
            logic [15:0] d;
            idx = int'($urandom_range(0, N - 1));
            n   = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       d = 16'd0;
                1:       d = 16'($urandom_range(1, 17));
                default: d = 16'($urandom);
            endcase
            do_txn(idx, n, d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0, 16'd0, 16'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0;
            req_num[i]   = 16'd0;
            req_den[i]   = 16'd0;
            rsp_ready[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_div_zero();
        test_back_pressure();
        test_reset_mid();
        test_stability();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
